// File: rtl/player_count_ctrl.sv
// player_count_ctrl
//   Debounced up/down/reset buttons driving a saturating 0..MAX_COUNT player
//   count, kept in binary and as a BCD digit pair for the display stage.
//   Inputs are already registered upstream, so no synchronizer is used here.
// Ports
//   clk, rst_n           : clock; synchronous active-low reset
//   up, down, reset      : registered button levels (reset = soft game clear)
//   count                : binary count 0..MAX_COUNT
//   bcd_tens, bcd_ones   : BCD digits of count, registered with count
//   changed              : one-cycle pulse after an edge where count changed
//   at_zero, at_max      : count == 0 / count == MAX_COUNT

// Single-button debouncer: a level is accepted after DB_CYCLES consecutive
// edges at the new value; any return to the stable level restarts the count.
module player_count_db #(
  parameter int DB_CYCLES = 500000,
  parameter int CW        = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_din,
  output logic o_stable,
  output logic o_press
);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_accept;

  assign w_accept = (i_din != r_stable) && (r_cnt == LAST);
  // Press is seen on the same edge the stable bit rises.
  assign o_press  = w_accept && i_din;
  assign o_stable = r_stable;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (i_din == r_stable) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_stable <= i_din;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

module player_count_ctrl #(
  parameter int DB_CYCLES = 500000,
  parameter int MAX_COUNT = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       up,
  input  logic       down,
  input  logic       reset,
  output logic [6:0] count,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       changed,
  output logic       at_zero,
  output logic       at_max
);
  localparam int              NUM_BTN = 3;
  localparam logic [6:0]      MAX_C   = 7'(MAX_COUNT);

  logic [NUM_BTN-1:0] w_btn, w_stable, w_press;
  logic               w_up_p, w_dn_p, w_clr;

  logic [6:0] r_count, w_nxt_count;
  logic [3:0] r_tens, r_ones, w_nxt_tens, w_nxt_ones;
  logic       r_changed;

  // Bit order: 0 = up, 1 = down, 2 = reset.
  assign w_btn = {reset, down, up};

  generate
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
      player_count_db #(.DB_CYCLES(DB_CYCLES)) u_db (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_din    (w_btn[g]),
        .o_stable (w_stable[g]),
        .o_press  (w_press[g])
      );
    end
  endgenerate

  assign w_up_p = w_press[0];
  assign w_dn_p = w_press[1];
  // Clear wins while the reset button is being pressed or held stable high.
  assign w_clr  = w_press[2] | w_stable[2];

  always_comb begin
    w_nxt_count = r_count;
    w_nxt_tens  = r_tens;
    w_nxt_ones  = r_ones;
    if (w_clr) begin
      w_nxt_count = '0;
      w_nxt_tens  = '0;
      w_nxt_ones  = '0;
    end else if (w_up_p && !w_dn_p && (r_count != MAX_C)) begin
      w_nxt_count = r_count + 7'd1;
      if (r_ones == 4'd9) begin
        w_nxt_ones = 4'd0;
        w_nxt_tens = r_tens + 4'd1;
      end else begin
        w_nxt_ones = r_ones + 4'd1;
      end
    end else if (w_dn_p && !w_up_p && (r_count != 7'd0)) begin
      w_nxt_count = r_count - 7'd1;
      if (r_ones == 4'd0) begin
        w_nxt_ones = 4'd9;
        w_nxt_tens = r_tens - 4'd1;
      end else begin
        w_nxt_ones = r_ones - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_tens    <= '0;
      r_ones    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_count   <= w_nxt_count;
      r_tens    <= w_nxt_tens;
      r_ones    <= w_nxt_ones;
      // Saturated, cancelled and zero-clear events leave count equal.
      r_changed <= (w_nxt_count != r_count);
    end
  end

  assign count    = r_count;
  assign bcd_tens = r_tens;
  assign bcd_ones = r_ones;
  assign changed  = r_changed;
  assign at_zero  = (r_count == 7'd0);
  assign at_max   = (r_count == MAX_C);
endmodule

// File: doc/player_count_ctrl.md
# player_count_ctrl

Debounced up/down player counter that sits directly downstream of the button-input register stage. It consumes the registered `up`, `down` and `reset` button levels and filters contact bounce on each one. It converts each clean press into exactly one count event and maintains a saturating 0..99 player count in BCD for the display stage. It also flags count changes and limits.

## Interface
- `DB_CYCLES`, 500000, consecutive cycles an input must hold a new level before it is accepted (5 ms at 100 MHz); minimum 2
- `MAX_COUNT`, 99, upper saturation limit; must be ≤ 99
- `clk` in 1: single clock; all logic on rising edge
- `rst_n` in 1: synchronous, active-low reset
- `up` in 1: registered up-button level from the input stage
- `down` in 1: registered down-button level
- `reset` in 1: registered game-reset button level (a soft clear, distinct from `rst_n`)
- `count` out 7: binary player count, 0..MAX_COUNT
- `bcd_tens` out 4: tens digit of `count`
- `bcd_ones` out 4: ones digit of `count`
- `changed` out 1: one-cycle pulse when `count` takes a new value
- `at_zero` out 1: `count == 0`
- `at_max` out 1: `count == MAX_COUNT`

## Operation
- Inputs are already registered by the upstream stage, so no synchronizer is used here.
- Three independent debouncers run on `up`, `down` and `reset`. Each has a stable state bit and a counter of width `$clog2(DB_CYCLES)`.
  - Per cycle, if the input equals the stable bit, the counter is cleared to 0.
  - If the input differs and the counter equals DB_CYCLES-1, the stable bit takes the input value and the counter is cleared.
  - Otherwise the counter increments.
- Press event: the stable bit transitions 0→1, detected on the same edge it updates. Release (1→0) generates no event. Holding a button never auto-repeats.
- Events resolve at each edge in strict priority:
  1. A `reset` press, or a stable `reset` still high, forces `count` to 0. Any up/down press on that edge or while `reset` is held stable high is discarded.
  2. An up press and a down press on the same edge cancel each other, so `count` is unchanged.
  3. An up press alone increments `count`, unless `count == MAX_COUNT`, in which case it saturates with no change.
  4. A down press alone decrements `count`, unless `count == 0`, in which case it stays at 0.
- `bcd_tens`/`bcd_ones` are registered alongside `count`. They update on the same edge and are maintained as a BCD pair (ones wraps 9→0 with tens carry/borrow), not by division.
- `changed` is registered high for exactly the cycle after an edge where `count` actually changed. A clear from nonzero counts as a change. A saturated, cancelled or zero-clear event does not.
- `at_zero`/`at_max` are combinational from the registered `count`.

## Timing
- `rst_n` low at an edge clears all debounce counters, stable bits, `count`, BCD digits and `changed` to 0. After reset, `at_zero`=1 and `at_max`=0.
- `rst_n` asserted mid-debounce discards the partial count. A press then needs a full DB_CYCLES after release of reset.
- Latency: an input held at a new level for DB_CYCLES consecutive sampled edges is accepted on the DB_CYCLES-th edge. `count` and the BCD digits update on that same edge, and `changed` is high during the following cycle.
- A level change shorter than DB_CYCLES cycles is fully rejected, and its counter restarts from 0.
- Re-press requires a release accepted by the debouncer (held low for DB_CYCLES) followed by a new accepted press.

## Test plan
All scenarios run with `DB_CYCLES`=4 and `MAX_COUNT`=99.
- **Reset:** `rst_n`=0 for 2 edges, inputs 0 → `count`=0, `bcd_tens`=0, `bcd_ones`=0, `at_zero`=1, `changed`=0.
- **Single press, no repeat:** `up`=1 for 4 edges → `count`=1 on the 4th edge and `changed` high for one cycle. Keep `up` high 20 more cycles → `count` stays 1 with no further `changed`.
- **Bounce rejection:** `up` 1,1,1,0,1,1,1,0 → `count` unchanged, `changed` never asserted.
- **Limits:** 99 clean up presses → `count`=99, `bcd_tens`=9, `bcd_ones`=9, `at_max`=1. A 100th press gives no change and no `changed` pulse.
  - BCD roll: count 10 followed by a down press gives tens 0, ones 9.
  - From 0, a down press keeps `count`=0 with no `changed` pulse.
- **Simultaneous and clear:** up and down both pressed, accepted on the same edge → no change. At `count`=42, a `reset` press gives `count`=0 plus a `changed` pulse. An up press while `reset` is still held high is ignored.
- **Reset mid-debounce:** `up`=1 for 2 edges, then `rst_n`=0 for 1 edge with `up` held → count is accepted only 4 edges after `rst_n` returns high.
